// File: rtl/cw_uart_time_tx.sv
// rtl/cw_uart_time_tx.sv - UART transmitter of the time of day as "HH:MM:SS\r\n" (8N1).
// Define CW_UART_TX_PARITY_EN to add an even-parity bit to every frame.
`timescale 1ns/1ps
module cw_uart_time_tx #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 17
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             i_Start,
  input  logic [CNT_W-1:0] i_Sec_Cnt,
  output logic             o_Txd,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [16:0]     rem_q, rem_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [2:0]      step_q, step_d;
  logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic            txd_q, txd_d;

  logic        accept;
  logic        baud_last;
  logic [31:0] sec_ext;
  logic [16:0] divisor;
  logic [7:0]  cur_byte;

  assign accept    = i_Start && (state_q == S_IDLE || state_q == S_DONE);
  assign baud_last = (baud_cnt_q == BW'(BAUD_DIV - 1));
  assign sec_ext   = 32'(i_Sec_Cnt);

  always_comb begin
    case (step_q)
      3'd0:    divisor = 17'd36000;
      3'd1:    divisor = 17'd3600;
      3'd2:    divisor = 17'd600;
      3'd3:    divisor = 17'd60;
      default: divisor = 17'd10;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      dig_q      <= '0;
      step_q     <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dig_q      <= dig_d;
      step_q     <= step_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dig_d      = dig_q;
    step_d     = step_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d    = S_CONV;
          // Out-of-range counts wrap to midnight, like the clock itself.
          rem_d      = (sec_ext >= 32'd86400) ? 17'd0 : sec_ext[16:0];
          dig_d      = '0;
          step_d     = '0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
        end
      end
      S_CONV: begin
        if (rem_q >= divisor) begin
          rem_d         = rem_q - divisor;
          dig_d[step_q] = dig_q[step_q] + 4'd1;
        end else if (step_q == 3'd4) begin
          dig_d[5] = rem_q[3:0];
          state_d  = S_START;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_START: begin
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + BW'(1);
        if (baud_last) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + BW'(1);
        if (baud_last) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef CW_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef CW_UART_TX_PARITY_EN
      S_PARITY: begin
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + BW'(1);
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + BW'(1);
        if (baud_last) begin
          if (byte_idx_q == 4'd9) begin
            state_d = S_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is derived from the next state so o_Txd stays aligned with the FSM.
  always_comb begin
    case (byte_idx_d)
      4'd0:    cur_byte = {4'h3, dig_q[0]};
      4'd1:    cur_byte = {4'h3, dig_q[1]};
      4'd3:    cur_byte = {4'h3, dig_q[2]};
      4'd4:    cur_byte = {4'h3, dig_q[3]};
      4'd6:    cur_byte = {4'h3, dig_q[4]};
      4'd7:    cur_byte = {4'h3, dig_q[5]};
      4'd8:    cur_byte = 8'h0D;
      4'd9:    cur_byte = 8'h0A;
      default: cur_byte = 8'h3A;
    endcase
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = cur_byte[bit_cnt_d];
`ifdef CW_UART_TX_PARITY_EN
      S_PARITY: txd_d = ^cur_byte;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign o_Txd  = txd_q;
  assign o_Busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_Done = (state_q == S_DONE);

endmodule

// File: tb/tb_cw_uart_time_tx.sv
// tb/tb_cw_uart_time_tx.sv - directed bench decoding the time message from o_Txd.
`timescale 1ns/1ps
module tb_cw_uart_time_tx;

  localparam int B = 4;
`ifdef CW_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int RST_AT = 21 + 5 * FB * B + 3 * B + 2;

  logic        CLK;
  logic        RSTn;
  logic        i_Start;
  logic [16:0] i_Sec_Cnt;
  logic        o_Txd;
  logic        o_Busy;
  logic        o_Done;

  cw_uart_time_tx #(.BAUD_DIV(B), .CNT_W(17)) dut (
    .CLK(CLK), .RSTn(RSTn), .i_Start(i_Start), .i_Sec_Cnt(i_Sec_Cnt),
    .o_Txd(o_Txd), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit trace[$];
  bit rec = 1'b0;
  int done_cnt = 0;
  int done_idx = -1;

  always @(negedge CLK) begin
    if (rec) begin
      trace.push_back(o_Txd);
      if (o_Done) begin
        done_cnt++;
        done_idx = trace.size() - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit samp(input int i);
    if (i >= 0 && i < trace.size()) return trace[i];
    return 1'b1;
  endfunction

  task automatic run_msg(input logic [16:0] sec, input logic [79:0] exp, input string tag,
                         input int disturb_at);
    int n, first, bad, base;
    logic [7:0] e, got;
    bit lvl;
    trace.delete();
    done_cnt = 0;
    done_idx = -1;
    rec = 1'b1;
    i_Sec_Cnt = sec;
    i_Start = 1'b1;
    @(negedge CLK);
    i_Start = 1'b0;
    check({tag, "_busy"}, 32'(o_Busy), 32'd1);
    n = 1;
    while (done_cnt == 0 && n < 200 + 10 * FB * B) begin
      @(negedge CLK);
      n++;
      if (disturb_at > 0 && n == disturb_at) begin
        i_Start = 1'b1;
        i_Sec_Cnt = 17'd100;
      end else begin
        i_Start = 1'b0;
      end
    end
    check({tag, "_timeout"}, 32'(done_cnt > 0), 32'd1);
    repeat (6) @(negedge CLK);
    rec = 1'b0;
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_end"}, 32'(o_Busy), 32'd0);
    first = -1;
    for (int i = 0; i < trace.size(); i++)
      if (first < 0 && trace[i] == 1'b0) first = i;
    check({tag, "_span"}, 32'(done_idx - first), 32'(10 * FB * B));
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      e = exp[79 - 8 * k -: 8];
      base = first + k * FB * B;
      got = '0;
      for (int j = 0; j < FB; j++) begin
        if (j == 0) lvl = 1'b0;
        else if (j <= 8) lvl = e[j - 1];
        else if (j == 9 && FB == 11) lvl = ^e;
        else lvl = 1'b1;
        for (int s = 0; s < B; s++)
          if (samp(base + j * B + s) != lvl) bad++;
        if (j >= 1 && j <= 8) got[j - 1] = samp(base + j * B + B / 2);
      end
      check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(e));
    end
    check({tag, "_frame_bits"}, 32'(bad), 32'd0);
`ifdef CW_UART_TX_PARITY_EN
    if (exp[79 -: 8] == 8'h31) begin
      check({tag, "_par31"}, 32'(samp(first + 9 * B + B / 2)), 32'd1);
      check({tag, "_par3a"}, 32'(samp(first + 2 * FB * B + 9 * B + B / 2)), 32'd0);
    end
`endif
  endtask

  initial begin
    RSTn = 1'b1;
    i_Start = 1'b0;
    i_Sec_Cnt = '0;
    #2 RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_txd", 32'(o_Txd), 32'd1);
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_done", 32'(o_Done), 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    run_msg(17'd45296,  80'h3132_3A33_343A_3536_0D0A, "t12_34_56", 0);
    run_msg(17'd86399,  80'h3233_3A35_393A_3539_0D0A, "t23_59_59", 0);
    run_msg(17'd0,      80'h3030_3A30_303A_3030_0D0A, "t_zero", 0);
    run_msg(17'd86400,  80'h3030_3A30_303A_3030_0D0A, "t_86400", 0);
    run_msg(17'd131071, 80'h3030_3A30_303A_3030_0D0A, "t_max", 0);
    run_msg(17'd45296,  80'h3132_3A33_343A_3536_0D0A, "t_busy_ign", 165);
    run_msg(17'd100,    80'h3030_3A30_313A_3430_0D0A, "t_00_01_40", 0);

    trace.delete();
    done_cnt = 0;
    rec = 1'b1;
    i_Sec_Cnt = 17'd45296;
    i_Start = 1'b1;
    @(negedge CLK);
    i_Start = 1'b0;
    repeat (RST_AT - 1) @(negedge CLK);
    check("pre_rst_txd", 32'(o_Txd), 32'd0);
    RSTn = 1'b0;
    #1;
    check("rst_mid_txd", 32'(o_Txd), 32'd1);
    check("rst_mid_busy", 32'(o_Busy), 32'd0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);
    rec = 1'b0;
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_idle", 32'(o_Busy), 32'd0);
    run_msg(17'd45296, 80'h3132_3A33_343A_3536_0D0A, "t_after_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cw_uart_time_tx.md
Name: cw_uart_time_tx

Overview:
UART transmitter that reports the clock time-of-day on the board's Uart_txd pin. On a start request it snapshots the 17-bit seconds count (0..86399), converts it sequentially into ASCII "HH:MM:SS\r\n" (10 bytes), and serialises the bytes as 8N1 frames. It sits beside the seven-segment display path, is fed from Sec_Cnt, and replaces the constant-high Uart_txd tie-off.

Parameters:
BAUD_DIV, 434, CLK cycles per UART bit (50 MHz / 115200); legal range >= 2
CNT_W, 17, width of the seconds-count input

Ports:
CLK  input  1  system clock (50 MHz)
RSTn  input  1  reset; asynchronous, active-low
i_Start  input  1  request to send one time message; sampled every CLK
i_Sec_Cnt  input  CNT_W  seconds since midnight
o_Txd  output  1  UART serial out; idle high
o_Busy  output  1  high from accept until the message completes
o_Done  output  1  one-cycle pulse when the last stop bit has finished

Behaviour:
- Reset (RSTn low, asynchronous): o_Txd=1, o_Busy=0, o_Done=0; FSM goes to IDLE; baud counter, bit counter and byte index are cleared.
- Accept:
  - i_Start high while o_Busy=0 is accepted on that CLK edge.
  - An accept during the o_Done cycle is also legal.
  - On accept, i_Sec_Cnt is captured into a snapshot register and o_Busy=1 from the next cycle.
- Ignored inputs while o_Busy=1:
  - i_Start is ignored. There is no queueing.
  - Changes on i_Sec_Cnt have no effect; the snapshot is used.
- Range rule: a snapshot >= 86400 is converted as 0, giving "00:00:00". This matches the clock's wrap rule.
- FSM states:
  - IDLE -> CONV on accept.
  - CONV -> START after the last digit is computed.
  - START -> DATA -> STOP.
  - STOP -> START if bytes remain; otherwise DONE.
  - DONE -> IDLE after exactly 1 cycle.
- CONV:
  - Digits are extracted by repeated subtraction of 36000, 3600, 600, 60 and 10, one subtraction per cycle. The remainder is the seconds-ones digit.
  - CONV lasts at most 40 cycles. o_Txd stays high throughout.
  - No combinational divide or modulo is used.
- Message byte order: Htens, Hones, 0x3A, Mtens, Mones, 0x3A, Stens, Sones, 0x0D, 0x0A. Each digit byte is 0x30 + d.
- Frame format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held on o_Txd for exactly BAUD_DIV CLK cycles.
  - o_Txd is registered (glitch-free).
- Byte spacing: bytes are sent back-to-back with no idle gap. Message duration from the first start-bit edge to the end of the last stop bit is exactly 100*BAUD_DIV cycles.
- DONE cycle: o_Busy=0, o_Done=1, o_Txd=1.
- Reset mid-operation: o_Txd returns high at once, o_Busy drops, and no o_Done pulse is produced. After RSTn rises the block is in IDLE; a truncated frame is never resumed.
- BAUD_DIV < 2 is unsupported; no checking is required.

Optional Feature:
Macro CW_UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit.
  - Frame is 11 bits; message duration is 110*BAUD_DIV cycles.
  - A PARITY state is added between DATA and STOP.
- Undefined: plain 8N1 framing, 10 bits per byte; no parity logic is synthesised.

Test Plan:
1. BAUD_DIV=4, i_Sec_Cnt=45296, pulse i_Start -> o_Txd carries 31 32 3A 33 34 3A 35 36 0D 0A; every bit lasts 4 cycles; the message spans 400 cycles; o_Done pulses once; o_Busy then falls.
2. i_Sec_Cnt=86399 -> "23:59:59\r\n" (32 33 3A 35 39 3A 35 39 0D 0A). i_Sec_Cnt=0 -> "00:00:00\r\n".
3. i_Sec_Cnt=86400, then 131071 -> both produce "00:00:00\r\n".
4. Start with 45296; during byte 3 pulse i_Start and change i_Sec_Cnt to 100 -> the full 12:34:56 message is sent unchanged, with a single o_Done. A later i_Start then sends "00:01:40\r\n".
5. Assert RSTn low mid-data-bit of byte 5 -> o_Txd=1 and o_Busy=0 asynchronously, and no o_Done. After release, i_Start sends a complete message.
6. With CW_UART_TX_PARITY_EN, BAUD_DIV=4, sending 45296 -> byte 0x31 has parity bit 1 and 0x3A has parity bit 0; each frame is 44 cycles; the message spans 440 cycles.
